popcount_accum_seq: RTL

//  Sequential popcount accumulator for ternary/binary neuron evaluation on wide activations.

---
 rtl/popcount_accum_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/popcount_accum_seq.sv
// rtl/popcount_accum_seq.sv - sequential popcount accumulator with threshold fire flag
//
// Purpose:
//    Takes frames of 1..MAX_BEATS activation words over a valid/ready stream.
//    For each frame it adds up the set bits, in exact or approximate (low-bit drop) mode.
//    It then returns the sum together with a threshold-fire flag and a force-close flag.
//
// Ports:
//    clk        in   1      clock, rising edge
//    rst        in   1      asynchronous active-high reset
//    in_valid   in   1      input beat valid
//    in_ready   out  1      block can accept a beat (low while a result is pending)
//    in_data    in   IN_W   activation bits
//    in_last    in   1      beat closes the frame
//    approx_en  in   1      approximate mode, sampled on the first beat of a frame
//    thr        in   ACC_W  fire threshold, sampled on the first beat of a frame
//    out_valid  out  1      result valid
//    out_ready  in   1      consumer accepts the result
//    out_sum    out  ACC_W  accumulated popcount (saturating)
//    out_fire   out  1      out_sum >= sampled thr (unsigned)
//    out_trunc  out  1      frame force-closed at MAX_BEATS without in_last
module popcount_accum_seq #(
   parameter int IN_W        = 27,
   parameter int MAX_BEATS   = 4,
   parameter int ACC_W       = 7,
   parameter int APPROX_DROP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   input  logic             approx_en,
   input  logic [ACC_W-1:0] thr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_fire,
   output logic             out_trunc
);

   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(MAX_BEATS - 1);
   localparam logic [ACC_W-1:0] ACC_MAX     = '1;
   localparam logic [ACC_W-1:0] APPROX_BIAS = ACC_W'(APPROX_DROP / 2);

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             approx_q, approx_d;
   logic [ACC_W-1:0] thr_q, thr_d;
   logic             fire_q, fire_d;
   logic             trunc_q, trunc_d;

   logic             accept;
   logic             first_beat;
   logic             mode;
   logic [ACC_W-1:0] thr_eff;
   logic [ACC_W-1:0] pc;
   logic [ACC_W-1:0] base;
   logic [ACC_W:0]   sum_wide;
   logic [ACC_W-1:0] sum_sat;
   logic             at_max;
   logic             close_frame;

   // Approx mode ignores the low APPROX_DROP bits and substitutes their expected
   // count (half of them set) so the result stays centred on the exact value.
   function automatic logic [ACC_W-1:0] beat_count(input logic [IN_W-1:0] d,
                                                   input logic            approx);
      logic [ACC_W-1:0] c;
      c = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (!approx || i >= APPROX_DROP) c = c + ACC_W'(d[i]);
      end
      if (approx) c = c + APPROX_BIAS;
      return c;
   endfunction

   assign in_ready  = (state_q != S_OUT);
   assign out_valid = (state_q == S_OUT);
   assign out_sum   = acc_q;
   assign out_fire  = fire_q;
   assign out_trunc = trunc_q;

   assign accept     = in_valid & in_ready;
   assign first_beat = (state_q == S_IDLE);
   // The first beat uses the live mode and threshold; later beats use the latched copies.
   assign mode       = first_beat ? approx_en : approx_q;
   assign thr_eff    = first_beat ? thr : thr_q;
   assign pc         = beat_count(in_data, mode);
   assign base       = first_beat ? '0 : acc_q;
   assign sum_wide   = {1'b0, base} + {1'b0, pc};
   assign sum_sat    = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
   // The beat being accepted is the MAX_BEATS-th of the frame.
   assign at_max      = first_beat ? (MAX_BEATS == 1) : (beat_cnt_q == LAST_CNT);
   assign close_frame = in_last | at_max;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      beat_cnt_d = beat_cnt_q;
      approx_d   = approx_q;
      thr_d      = thr_q;
      fire_d     = fire_q;
      trunc_d    = trunc_q;
      case (state_q)
         S_IDLE, S_ACC: begin
            if (accept) begin
               acc_d      = sum_sat;
               beat_cnt_d = first_beat ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
               if (first_beat) begin
                  approx_d = approx_en;
                  thr_d    = thr;
               end
               if (close_frame) begin
                  state_d = S_OUT;
                  fire_d  = (sum_sat >= thr_eff);
                  trunc_d = at_max & ~in_last;
               end else begin
                  state_d = S_ACC;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d    = S_IDLE;
               acc_d      = '0;
               beat_cnt_d = '0;
               fire_d     = 1'b0;
               trunc_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         beat_cnt_q <= '0;
         approx_q   <= 1'b0;
         thr_q      <= '0;
         fire_q     <= 1'b0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         beat_cnt_q <= beat_cnt_d;
         approx_q   <= approx_d;
         thr_q      <= thr_d;
         fire_q     <= fire_d;
         trunc_q    <= trunc_d;
      end
   end

endmodule
